wiredpanda_gate_bank: RTL and testbench

//  Parametrised, clocked successor to the flat combinational gate-to-LED netlist.

---
 rtl/wiredpanda_pkg.sv | 44 ++++
 rtl/wp_led_stretch.sv | 37 +++
 rtl/wiredpanda_gate_bank.sv | 116 +++++++++++
 tb/tb_wiredpanda_gate_bank.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wiredpanda_pkg.sv
// Shared definitions for the gate bank: opcode values, the output-stage
// occupancy encoding and the bitwise gate function used by every lane.
package wiredpanda_pkg;

   localparam int OP_W = 3;

   localparam logic [OP_W-1:0] OP_AND  = 3'd0;
   localparam logic [OP_W-1:0] OP_OR   = 3'd1;
   localparam logic [OP_W-1:0] OP_XOR  = 3'd2;
   localparam logic [OP_W-1:0] OP_NOTA = 3'd3;
   localparam logic [OP_W-1:0] OP_NAND = 3'd4;
   localparam logic [OP_W-1:0] OP_NOR  = 3'd5;
   localparam logic [OP_W-1:0] OP_XNOR = 3'd6;
   localparam logic [OP_W-1:0] OP_BUF  = 3'd7;

   // Widest lane the gate function handles; callers size-cast in and out.
   localparam int GATE_MAX_W = 64;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } occ_state_e;

   function automatic logic [GATE_MAX_W-1:0] gate_eval(
      input logic [OP_W-1:0]       op,
      input logic [GATE_MAX_W-1:0] a,
      input logic [GATE_MAX_W-1:0] b
   );
      logic [GATE_MAX_W-1:0] r;
      case (op)
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_XOR:  r = a ^ b;
         OP_NOTA: r = ~a;
         OP_NAND: r = ~(a & b);
         OP_NOR:  r = ~(a | b);
         OP_XNOR: r = ~(a ^ b);
         default: r = a;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/wp_led_stretch.sv
// Retriggerable pulse stretcher: a trigger (re)loads the on-time counter,
// which then counts down; the LED is lit while the counter is nonzero.
module wp_led_stretch #(
   parameter int STRETCH = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic trig,
   output logic led
);

   localparam int CW = $clog2(STRETCH + 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Reload rather than accumulate, so a retrigger never exceeds STRETCH.
   always_comb begin
      cnt_d = cnt_q;
      if (trig) begin
         cnt_d = CW'(STRETCH);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign led = (cnt_q != '0);

endmodule

// File: rtl/wiredpanda_gate_bank.sv
// CHANNELS gate lanes feeding a 2-entry skid-buffered valid/ready output,
// with one LED stretcher per lane driven by accepted (not delivered) beats.
module wiredpanda_gate_bank
   import wiredpanda_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int WIDTH    = 1,
   parameter int STRETCH  = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [OP_W*CHANNELS-1:0]  in_op,
   input  logic [WIDTH*CHANNELS-1:0] in_a,
   input  logic [WIDTH*CHANNELS-1:0] in_b,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [WIDTH*CHANNELS-1:0] out_data,
   output logic [CHANNELS-1:0]       led
);

   localparam int DW = WIDTH * CHANNELS;

   occ_state_e    state_q;
   occ_state_e    state_d;
   logic [DW-1:0] data_q;
   logic [DW-1:0] data_d;
   logic [DW-1:0] skid_q;
   logic [DW-1:0] skid_d;
   logic          in_ready_q;
   logic          out_valid_q;

   logic [DW-1:0]       res;
   logic [CHANNELS-1:0] lane_hit;
   logic                in_xfer;
   logic                out_xfer;

   assign in_xfer  = in_valid & in_ready_q;
   assign out_xfer = out_valid_q & out_ready;

   generate
      for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
         assign res[WIDTH*gi +: WIDTH] = WIDTH'(gate_eval(
            in_op[OP_W*gi +: OP_W],
            GATE_MAX_W'(in_a[WIDTH*gi +: WIDTH]),
            GATE_MAX_W'(in_b[WIDTH*gi +: WIDTH])));

         assign lane_hit[gi] = in_xfer & (res[WIDTH*gi +: WIDTH] != '0);

         wp_led_stretch #(
            .STRETCH (STRETCH)
         ) u_stretch (
            .clk   (clk),
            .rst_n (rst_n),
            .trig  (lane_hit[gi]),
            .led   (led[gi])
         );
      end
   endgenerate

   // data_q is always the head of the FIFO; skid_q only holds the second beat.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      skid_d  = skid_q;
      unique case (state_q)
         OCC_EMPTY: begin
            if (in_xfer) begin
               data_d  = res;
               state_d = OCC_ONE;
            end
         end
         OCC_ONE: begin
            case ({in_xfer, out_xfer})
               2'b10: begin
                  skid_d  = res;
                  state_d = OCC_FULL;
               end
               2'b01: state_d = OCC_EMPTY;
               2'b11: data_d  = res;
               default: ;
            endcase
         end
         OCC_FULL: begin
            if (out_xfer) begin
               data_d  = skid_q;
               state_d = OCC_ONE;
            end
         end
         default: state_d = OCC_EMPTY;
      endcase
   end

   // Handshake outputs come from the next state so in_ready never sees out_ready combinationally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= OCC_EMPTY;
         data_q      <= '0;
         skid_q      <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         data_q      <= data_d;
         skid_q      <= skid_d;
         in_ready_q  <= (state_d != OCC_FULL);
         out_valid_q <= (state_d != OCC_EMPTY);
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = data_q;

endmodule

// File: tb/tb_wiredpanda_gate_bank.sv
// Scoreboard bench: the driver issues beats, the monitor predicts results from
// gate truth tables, tracks FIFO occupancy and LED on-windows, and compares.
module tb_wiredpanda_gate_bank;

   localparam int CH  = 4;
   localparam int W   = 1;
   localparam int S   = 4;
   localparam int DW  = CH * W;
   localparam int OPW = 3 * CH;

   logic           clk;
   logic           rst_n;
   logic           in_valid;
   logic           in_ready;
   logic [OPW-1:0] in_op;
   logic [DW-1:0]  in_a;
   logic [DW-1:0]  in_b;
   logic           out_valid;
   logic           out_ready;
   logic [DW-1:0]  out_data;
   logic [CH-1:0]  led;

   int cmp_count = 0;
   int err_count = 0;
   logic [DW-1:0] exp_q[$];

   wiredpanda_gate_bank #(
      .CHANNELS (CH),
      .WIDTH    (W),
      .STRETCH  (S)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .led       (led)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input longint act, input longint exp);
      cmp_count++;
      if (act != exp) begin
         err_count++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Truth table indexed by {a,b}: bit3 = (1,1) ... bit0 = (0,0).
   function automatic logic [3:0] truth(input logic [2:0] op);
      case (op)
         3'd0:    return 4'b1000;
         3'd1:    return 4'b1110;
         3'd2:    return 4'b0110;
         3'd3:    return 4'b0011;
         3'd4:    return 4'b0111;
         3'd5:    return 4'b0001;
         3'd6:    return 4'b1001;
         default: return 4'b1100;
      endcase
   endfunction

   function automatic logic [DW-1:0] model_res(input logic [OPW-1:0] op,
                                               input logic [DW-1:0] a,
                                               input logic [DW-1:0] b);
      logic [DW-1:0] r;
      logic [3:0]    tt;
      r = '0;
      for (int l = 0; l < CH; l++) begin
         tt = truth(op[3*l +: 3]);
         for (int k = 0; k < W; k++) begin
            r[W*l+k] = tt[{a[W*l+k], b[W*l+k]}];
         end
      end
      return r;
   endfunction

   // Monitor / scoreboard
   initial begin
      int            samp;
      int            occ;
      int            last_trig[CH];
      bit            fresh;
      bit            prev_stall;
      logic [DW-1:0] prev_data;
      logic [DW-1:0] r;
      logic [CH-1:0] led_exp;
      samp = 0;
      occ = 0;
      fresh = 1'b1;
      prev_stall = 1'b0;
      prev_data = '0;
      for (int l = 0; l < CH; l++) last_trig[l] = -1000;
      forever begin
         @(negedge clk);
         #1;
         samp++;
         if (!rst_n) begin
            check("rst_out_valid", longint'(out_valid), 0);
            check("rst_in_ready", longint'(in_ready), 1);
            check("rst_out_data", longint'(out_data), 0);
            check("rst_led", longint'(led), 0);
            exp_q.delete();
            occ = 0;
            fresh = 1'b1;
            prev_stall = 1'b0;
            for (int l = 0; l < CH; l++) last_trig[l] = -1000;
         end else begin
            check("in_ready", longint'(in_ready), longint'(occ < 2));
            check("out_valid", longint'(out_valid), longint'(occ > 0));
            for (int l = 0; l < CH; l++) begin
               led_exp[l] = ((samp - last_trig[l]) >= 1) && ((samp - last_trig[l]) <= S);
            end
            check("led", longint'(led), longint'(led_exp));
            if (fresh) check("idle_out_data", longint'(out_data), 0);
            if (prev_stall) check("hold_out_data", longint'(out_data), longint'(prev_data));
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  check("spurious_out", longint'(out_valid), 0);
               end else begin
                  r = exp_q.pop_front();
                  check("out_data", longint'(out_data), longint'(r));
               end
               if (occ > 0) occ--;
            end
            if (in_valid && in_ready) begin
               r = model_res(in_op, in_a, in_b);
               exp_q.push_back(r);
               occ++;
               fresh = 1'b0;
               for (int l = 0; l < CH; l++) begin
                  if (r[W*l +: W] != '0) last_trig[l] = samp;
               end
            end
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
         end
      end
   end

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic send(input logic [OPW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
      int n;
      in_valid = 1'b1;
      in_op = op;
      in_a = a;
      in_b = b;
      n = 0;
      while (!in_ready) begin
         if (n == 200) begin
            check("send_timeout", longint'(in_ready), 1);
            break;
         end
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   function automatic logic [OPW-1:0] all_ops(input logic [2:0] op);
      logic [OPW-1:0] v;
      for (int l = 0; l < CH; l++) v[3*l +: 3] = op;
      return v;
   endfunction

   // Driver
   initial begin
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      in_op = '0;
      in_a = '0;
      in_b = '0;

      // Reset held with random inputs, then quiet after release
      repeat (4) begin
         @(negedge clk);
         in_valid = 1'($urandom);
         out_ready = 1'($urandom);
         in_op = OPW'($urandom);
         in_a = DW'($urandom);
         in_b = DW'($urandom);
      end
      @(negedge clk);
      rst_n = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      idle(3);

      // Every op against every (a,b) pair
      for (int op = 0; op < 8; op++) begin
         for (int ab = 0; ab < 4; ab++) begin
            for (int l = 0; l < CH; l++) begin
               a[W*l +: W] = {W{ab[1]}};
               b[W*l +: W] = {W{ab[0]}};
            end
            send(all_ops(3'(op)), a, b);
         end
      end
      idle(3);

      // Random traffic with random backpressure
      repeat (300) begin
         in_valid = 1'($urandom);
         out_ready = ($urandom_range(0, 9) < 7);
         in_op = OPW'($urandom);
         in_a = DW'($urandom);
         in_b = DW'($urandom);
         @(negedge clk);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      idle(5);

      // Backpressure: beats 1,2 fill the buffer, beat 3 waits at the input
      out_ready = 1'b0;
      send(all_ops(3'd7), DW'(1), '0);
      send(all_ops(3'd7), DW'(2), '0);
      in_valid = 1'b1;
      in_op = all_ops(3'd7);
      in_a = DW'(3);
      repeat (4) @(negedge clk);
      out_ready = 1'b1;
      send(all_ops(3'd7), DW'(3), '0);
      idle(5);

      // Simultaneous in/out transfers while one beat is held
      out_ready = 1'b0;
      send(OPW'($urandom), DW'($urandom), DW'($urandom));
      out_ready = 1'b1;
      repeat (10) begin
         in_valid = 1'b1;
         in_op = OPW'($urandom);
         in_a = DW'($urandom);
         in_b = DW'($urandom);
         @(negedge clk);
      end
      idle(5);

      // LED: single hit, retrigger two cycles later, then an all-zero beat
      idle(8);
      send(all_ops(3'd7), DW'(1), '0);
      idle(8);
      send(all_ops(3'd7), DW'(1), '0);
      idle(1);
      send(all_ops(3'd7), DW'(1), '0);
      idle(10);
      send(all_ops(3'd0), '0, DW'($urandom));
      idle(6);

      // Reset while the buffer is full
      out_ready = 1'b0;
      send(all_ops(3'd7), DW'($urandom_range(1, (1 << DW) - 1)), '0);
      send(all_ops(3'd7), DW'($urandom_range(1, (1 << DW) - 1)), '0);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_out_valid", longint'(out_valid), 0);
      check("async_in_ready", longint'(in_ready), 1);
      check("async_out_data", longint'(out_data), 0);
      check("async_led", longint'(led), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      idle(6);

      // Recovery traffic after reset
      repeat (60) begin
         in_valid = 1'($urandom);
         out_ready = 1'($urandom);
         in_op = OPW'($urandom);
         in_a = DW'($urandom);
         in_b = DW'($urandom);
         @(negedge clk);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      idle(8);

      check("queue_drained", longint'(exp_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, compared %0d", cmp_count);
      $fatal(1, "watchdog expired");
   end

endmodule
